// File: rtl/cordic_arbiter.sv
// -----------------------------------------------------------------------------
// cordic_arbiter
//
// Purpose:
//   Shares one CORDIC engine between two requesters. A job is accepted from one
//   requester, its operands and control halfword are latched and handed to the
//   engine with a one-cycle "start" write of the control register. The arbiter
//   then waits for the engine's completion pulse, captures the results and
//   presents them to the requester that owns the job. When both requesters are
//   waiting, the grant alternates. A requester that is alone keeps being served.
//
// Optional feature (macro CORDIC_ARB_TIMEOUT_EN):
//   Adds a watchdog that counts cycles spent waiting for the engine. When the
//   count reaches p_TIMEOUT, a one-cycle "stop" write (cordicCtrl[1]) is issued.
//   The arbiter still waits for cordicDone and then flags the response with
//   rspTimeout. Without the macro there is no counter and rspTimeout stays 0.
//
// Ports:
//   clk, rstN                      clock, asynchronous active-low reset
//   reqValid/reqReady [1:0]        job request handshake, bit i = requester i
//   reqX/reqY/reqZ [2*p_WIDTH]     packed operands, requester i at [i*p_WIDTH +: p_WIDTH]
//   reqCtrl [31:0]                 packed 16-bit control halfword per requester
//   rspValid/rspReady [1:0]        result handshake, bit i = requester i
//   rspX/rspY/rspZ [p_WIDTH]       shared result bus
//   rspFlags [15:0]                engine status flag half (status[31:16])
//   rspTimeout                     watchdog fired during this job
//   cordicCtrl [31:0]              engine control-register write
//   cordicX/cordicY/cordicZ        engine operands
//   cordicDone                     engine completion pulse
//   cordicStatus, cordicXRes/YRes/ZRes  engine results
//   busy                           high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module cordic_arbiter #(
   parameter int p_WIDTH   = 32,
   parameter int p_TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic [1:0]             reqValid,
   output logic [1:0]             reqReady,
   input  logic [2*p_WIDTH-1:0]   reqX,
   input  logic [2*p_WIDTH-1:0]   reqY,
   input  logic [2*p_WIDTH-1:0]   reqZ,
   input  logic [31:0]            reqCtrl,
   output logic [1:0]             rspValid,
   input  logic [1:0]             rspReady,
   output logic [p_WIDTH-1:0]     rspX,
   output logic [p_WIDTH-1:0]     rspY,
   output logic [p_WIDTH-1:0]     rspZ,
   output logic [15:0]            rspFlags,
   output logic                   rspTimeout,
   output logic [31:0]            cordicCtrl,
   output logic [p_WIDTH-1:0]     cordicX,
   output logic [p_WIDTH-1:0]     cordicY,
   output logic [p_WIDTH-1:0]     cordicZ,
   input  logic                   cordicDone,
   input  logic [31:0]            cordicStatus,
   input  logic [p_WIDTH-1:0]     cordicXRes,
   input  logic [p_WIDTH-1:0]     cordicYRes,
   input  logic [p_WIDTH-1:0]     cordicZRes,
   output logic                   busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      RESPOND = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                grant_q, grant_d;
   logic [p_WIDTH-1:0]  op_x_q, op_x_d;
   logic [p_WIDTH-1:0]  op_y_q, op_y_d;
   logic [p_WIDTH-1:0]  op_z_q, op_z_d;
   logic [13:0]         ctrl_q, ctrl_d;
   logic [31:0]         cordic_ctrl_q, cordic_ctrl_d;
   logic [1:0]          rsp_valid_q, rsp_valid_d;
   logic [p_WIDTH-1:0]  rsp_x_q, rsp_x_d;
   logic [p_WIDTH-1:0]  rsp_y_q, rsp_y_d;
   logic [p_WIDTH-1:0]  rsp_z_q, rsp_z_d;
   logic [15:0]         rsp_flags_q, rsp_flags_d;
   logic                rsp_timeout_q, rsp_timeout_d;
   logic                busy_q, busy_d;

   logic                grant_sel;
   logic [1:0]          req_ready;
   logic [p_WIDTH-1:0]  sel_x, sel_y, sel_z;
   logic [13:0]         sel_ctrl;

   // Watchdog interface seen by the main FSM: wd_fire requests the stop write,
   // wd_expired_q remembers that it happened for the current job.
   logic                wd_fire;
   logic                wd_expired_q;

   // Low two bits of each control halfword, bits 17:16 and the engine's
   // non-flag status half carry nothing this block needs.
   logic                unused_bits;
   assign unused_bits = ^{reqCtrl[17:16], reqCtrl[1:0], cordicStatus[15:0]};

`ifdef CORDIC_ARB_TIMEOUT_EN
   localparam int               CNT_W   = $clog2(p_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(p_TIMEOUT);

   logic [CNT_W-1:0]    wd_cnt_q, wd_cnt_d;
   logic                wd_expired_d;

   // The counter is cleared while the job is being issued so it starts at
   // zero on the first WAIT cycle, then saturates at p_TIMEOUT. The stop
   // request is raised on the single cycle where the count first hits the
   // limit, so the engine sees exactly one stop write per job.
   always_comb begin
      wd_cnt_d     = wd_cnt_q;
      wd_expired_d = wd_expired_q;
      if (state_q == ISSUE) begin
         wd_cnt_d     = '0;
         wd_expired_d = 1'b0;
      end else if ((state_q == WAIT) && !cordicDone && (wd_cnt_q != CNT_MAX)) begin
         wd_cnt_d = wd_cnt_q + 1'b1;
         if (wd_cnt_d == CNT_MAX) begin
            wd_expired_d = 1'b1;
         end
      end
   end

   assign wd_fire = wd_expired_d & ~wd_expired_q;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         wd_cnt_q     <= '0;
         wd_expired_q <= 1'b0;
      end else begin
         wd_cnt_q     <= wd_cnt_d;
         wd_expired_q <= wd_expired_d;
      end
   end
`else
   logic                unused_param;
   assign unused_param = (p_TIMEOUT > 0);
   assign wd_fire      = 1'b0;
   assign wd_expired_q = 1'b0;
`endif

   // Grant selection: a lone requester always wins; on a tie the requester
   // that did not win last time is chosen. With no request the value is a
   // don't-care because reqReady stays low.
   always_comb begin
      grant_sel = reqValid[1];
      if (reqValid == 2'b11) begin
         grant_sel = ~last_grant_q;
      end
      req_ready = 2'b00;
      if ((state_q == IDLE) && (reqValid != 2'b00)) begin
         req_ready[grant_sel] = 1'b1;
      end
      sel_x    = grant_sel ? reqX[2*p_WIDTH-1:p_WIDTH] : reqX[p_WIDTH-1:0];
      sel_y    = grant_sel ? reqY[2*p_WIDTH-1:p_WIDTH] : reqY[p_WIDTH-1:0];
      sel_z    = grant_sel ? reqZ[2*p_WIDTH-1:p_WIDTH] : reqZ[p_WIDTH-1:0];
      sel_ctrl = grant_sel ? reqCtrl[31:18] : reqCtrl[15:2];
   end

   assign reqReady = req_ready;

   // Next-state logic. Every output except reqReady is a register, so the
   // control-register value for a state is prepared on the transition into it:
   // the start write appears exactly during ISSUE, and rspValid rises on the
   // cycle after cordicDone. cordicDone is only looked at in WAIT.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      grant_d       = grant_q;
      op_x_d        = op_x_q;
      op_y_d        = op_y_q;
      op_z_d        = op_z_q;
      ctrl_d        = ctrl_q;
      cordic_ctrl_d = 32'h0;
      rsp_valid_d   = rsp_valid_q;
      rsp_x_d       = rsp_x_q;
      rsp_y_d       = rsp_y_q;
      rsp_z_d       = rsp_z_q;
      rsp_flags_d   = rsp_flags_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         IDLE: begin
            if ((reqValid & req_ready) != 2'b00) begin
               grant_d       = grant_sel;
               op_x_d        = sel_x;
               op_y_d        = sel_y;
               op_z_d        = sel_z;
               ctrl_d        = sel_ctrl;
               cordic_ctrl_d = {16'h0, sel_ctrl, 2'b01};
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            if (cordicDone) begin
               rsp_x_d              = cordicXRes;
               rsp_y_d              = cordicYRes;
               rsp_z_d              = cordicZRes;
               rsp_flags_d          = cordicStatus[31:16];
               rsp_timeout_d        = wd_expired_q;
               rsp_valid_d          = 2'b00;
               rsp_valid_d[grant_q] = 1'b1;
               state_d              = RESPOND;
            end else if (wd_fire) begin
               cordic_ctrl_d = {16'h0, ctrl_q, 2'b10};
            end
         end
         RESPOND: begin
            if (rspReady[grant_q]) begin
               rsp_valid_d  = 2'b00;
               last_grant_d = grant_q;
               state_d      = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and registered outputs. Reset drops any job in flight; lastGrant
   // resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q       <= IDLE;
         last_grant_q  <= 1'b1;
         grant_q       <= 1'b0;
         op_x_q        <= '0;
         op_y_q        <= '0;
         op_z_q        <= '0;
         ctrl_q        <= '0;
         cordic_ctrl_q <= 32'h0;
         rsp_valid_q   <= 2'b00;
         rsp_x_q       <= '0;
         rsp_y_q       <= '0;
         rsp_z_q       <= '0;
         rsp_flags_q   <= 16'h0;
         rsp_timeout_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         grant_q       <= grant_d;
         op_x_q        <= op_x_d;
         op_y_q        <= op_y_d;
         op_z_q        <= op_z_d;
         ctrl_q        <= ctrl_d;
         cordic_ctrl_q <= cordic_ctrl_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_x_q       <= rsp_x_d;
         rsp_y_q       <= rsp_y_d;
         rsp_z_q       <= rsp_z_d;
         rsp_flags_q   <= rsp_flags_d;
         rsp_timeout_q <= rsp_timeout_d;
         busy_q        <= busy_d;
      end
   end

   assign cordicCtrl = cordic_ctrl_q;
   assign cordicX    = op_x_q;
   assign cordicY    = op_y_q;
   assign cordicZ    = op_z_q;
   assign rspValid   = rsp_valid_q;
   assign rspX       = rsp_x_q;
   assign rspY       = rsp_y_q;
   assign rspZ       = rsp_z_q;
   assign rspFlags   = rsp_flags_q;
   assign rspTimeout = rsp_timeout_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cordic_arbiter
//
// Self-checking bench for cordic_arbiter. The bench plays both requesters and
// the CORDIC engine. A small model keeps the round-robin winner, the operands
// offered by each requester and the results the engine produced, and every
// DUT output is compared against it. Compile with CORDIC_ARB_TIMEOUT_EN to
// exercise the watchdog; without it the long-wait behaviour is checked.
// -----------------------------------------------------------------------------
module tb_cordic_arbiter;

   localparam int W          = 32;
   localparam int TB_TIMEOUT = 8;
`ifdef CORDIC_ARB_TIMEOUT_EN
   localparam int SINGLE_WAIT = 5;
`else
   localparam int SINGLE_WAIT = 19;
`endif

   logic           clk;
   logic           rstN;
   logic [1:0]     reqValid;
   logic [1:0]     reqReady;
   logic [2*W-1:0] reqX, reqY, reqZ;
   logic [31:0]    reqCtrl;
   logic [1:0]     rspValid;
   logic [1:0]     rspReady;
   logic [W-1:0]   rspX, rspY, rspZ;
   logic [15:0]    rspFlags;
   logic           rspTimeout;
   logic [31:0]    cordicCtrl;
   logic [W-1:0]   cordicX, cordicY, cordicZ;
   logic           cordicDone;
   logic [31:0]    cordicStatus;
   logic [W-1:0]   cordicXRes, cordicYRes, cordicZRes;
   logic           busy;

   cordic_arbiter #(
      .p_WIDTH   (W),
      .p_TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk          (clk),
      .rstN         (rstN),
      .reqValid     (reqValid),
      .reqReady     (reqReady),
      .reqX         (reqX),
      .reqY         (reqY),
      .reqZ         (reqZ),
      .reqCtrl      (reqCtrl),
      .rspValid     (rspValid),
      .rspReady     (rspReady),
      .rspX         (rspX),
      .rspY         (rspY),
      .rspZ         (rspZ),
      .rspFlags     (rspFlags),
      .rspTimeout   (rspTimeout),
      .cordicCtrl   (cordicCtrl),
      .cordicX      (cordicX),
      .cordicY      (cordicY),
      .cordicZ      (cordicZ),
      .cordicDone   (cordicDone),
      .cordicStatus (cordicStatus),
      .cordicXRes   (cordicXRes),
      .cordicYRes   (cordicYRes),
      .cordicZRes   (cordicZRes),
      .busy         (busy)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Model state: last winner, per-requester operands, expected results.
   int          last_model;
   logic [W-1:0] mx [2];
   logic [W-1:0] my [2];
   logic [W-1:0] mz [2];
   logic [15:0]  mctrl [2];
   logic [W-1:0] ex_x, ex_y, ex_z;
   logic [15:0]  ex_flags;

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_reqReady"}, 64'(reqReady), 64'h0);
      checkOutput({tag, "_rspValid"}, 64'(rspValid), 64'h0);
      checkOutput({tag, "_cordicCtrl"}, 64'(cordicCtrl), 64'h0);
      checkOutput({tag, "_cordicXYZ"}, 64'(cordicX | cordicY | cordicZ), 64'h0);
      checkOutput({tag, "_rspXYZ"}, 64'(rspX | rspY | rspZ), 64'h0);
      checkOutput({tag, "_rspFlags"}, 64'(rspFlags), 64'h0);
      checkOutput({tag, "_rspTimeout"}, 64'(rspTimeout), 64'h0);
      checkOutput({tag, "_busy"}, 64'(busy), 64'h0);
   endtask

   task automatic apply_reset();
      reqValid   = 2'b00;
      rspReady   = 2'b00;
      cordicDone = 1'b0;
      rstN       = 1'b0;
      tick();
      tick();
      check_all_zero("reset");
      rstN       = 1'b1;
      last_model = 1;
      tick();
   endtask

   // Offer a job with the given valid mask and randomized operands, check the
   // grant against the round-robin rule, then check the ISSUE cycle.
   task automatic start_job(input logic [1:0] mask, output int g);
      logic [1:0] onehot;
      for (int i = 0; i < 2; i++) begin
         mx[i]    = $urandom;
         my[i]    = $urandom;
         mz[i]    = $urandom;
         mctrl[i] = 16'($urandom);
      end
      reqX     = {mx[1], mx[0]};
      reqY     = {my[1], my[0]};
      reqZ     = {mz[1], mz[0]};
      reqCtrl  = {mctrl[1], mctrl[0]};
      reqValid = mask;
      if (mask == 2'b11) g = 1 - last_model;
      else if (mask == 2'b10) g = 1;
      else g = 0;
      onehot = 2'(1 << g);
      #1;
      checkOutput("grant_ready", 64'(reqReady), 64'(onehot));
      tick();
      reqValid = mask & ~onehot;
      checkOutput("issue_ctrl", 64'(cordicCtrl), 64'((mctrl[g] & 16'hFFFC) + 16'd1));
      checkOutput("issue_x", 64'(cordicX), 64'(mx[g]));
      checkOutput("issue_y", 64'(cordicY), 64'(my[g]));
      checkOutput("issue_z", 64'(cordicZ), 64'(mz[g]));
      checkOutput("issue_busy", 64'(busy), 64'h1);
      checkOutput("issue_ready", 64'(reqReady), 64'h0);
   endtask

   // Engine completion, response checks, optional backpressure, handshake.
   task automatic finish_job(input int g, input int hold_cycles, input logic exp_to);
      logic [1:0] onehot;
      logic [31:0] status;
      onehot       = 2'(1 << g);
      ex_x         = $urandom;
      ex_y         = $urandom;
      ex_z         = $urandom;
      status       = $urandom;
      ex_flags     = status[31:16];
      cordicXRes   = ex_x;
      cordicYRes   = ex_y;
      cordicZRes   = ex_z;
      cordicStatus = status;
      cordicDone   = 1'b1;
      tick();
      cordicDone   = 1'b0;
      cordicXRes   = $urandom;
      cordicYRes   = $urandom;
      cordicZRes   = $urandom;
      cordicStatus = $urandom;
      checkOutput("rsp_valid", 64'(rspValid), 64'(onehot));
      checkOutput("rsp_x", 64'(rspX), 64'(ex_x));
      checkOutput("rsp_y", 64'(rspY), 64'(ex_y));
      checkOutput("rsp_z", 64'(rspZ), 64'(ex_z));
      checkOutput("rsp_flags", 64'(rspFlags), 64'(ex_flags));
      checkOutput("rsp_timeout", 64'(rspTimeout), 64'(exp_to));
      // The other requester's ready must not complete this response.
      rspReady = ~onehot;
      for (int k = 0; k < hold_cycles; k++) begin
         tick();
         checkOutput("hold_valid", 64'(rspValid), 64'(onehot));
         checkOutput("hold_x", 64'(rspX), 64'(ex_x));
         checkOutput("hold_flags", 64'(rspFlags), 64'(ex_flags));
         checkOutput("hold_ctrl", 64'(cordicCtrl), 64'h0);
         checkOutput("hold_ready", 64'(reqReady), 64'h0);
      end
      rspReady = onehot;
      tick();
      rspReady = 2'b00;
      last_model = g;
      checkOutput("done_valid", 64'(rspValid), 64'h0);
      checkOutput("done_busy", 64'(busy), 64'h0);
   endtask

   task automatic applyStimulus(input logic [1:0] mask, input int wait_cycles, input int hold_cycles);
      int g;
      start_job(mask, g);
      for (int k = 0; k < wait_cycles; k++) begin
         tick();
         checkOutput("wait_ctrl", 64'(cordicCtrl), 64'h0);
         checkOutput("wait_ready", 64'(reqReady), 64'h0);
         checkOutput("wait_rsp", 64'(rspValid), 64'h0);
      end
      finish_job(g, hold_cycles, 1'b0);
   endtask

   initial begin
      int g;
      logic ok;
      logic [1:0] mask;
      reqValid     = 2'b00;
      rspReady     = 2'b00;
      reqX         = '0;
      reqY         = '0;
      reqZ         = '0;
      reqCtrl      = '0;
      cordicDone   = 1'b0;
      cordicStatus = '0;
      cordicXRes   = '0;
      cordicYRes   = '0;
      cordicZRes   = '0;
      rstN         = 1'b0;
      last_model   = 1;

      $display("[TB] reset");
      apply_reset();

      $display("[TB] single job with the reference operands");
      reqValid = 2'b01;
      reqX     = {32'h0, 32'h20000000};
      reqY     = '0;
      reqZ     = {32'h0, 32'h10000000};
      reqCtrl  = {16'h0, 16'h1F2C};
      #1;
      checkOutput("single_ready", 64'(reqReady), 64'h1);
      tick();
      reqValid = 2'b00;
      checkOutput("single_ctrl", 64'(cordicCtrl), 64'h00001F2D);
      checkOutput("single_x", 64'(cordicX), 64'h20000000);
      checkOutput("single_z", 64'(cordicZ), 64'h10000000);
      tick();
      checkOutput("single_ctrl_once", 64'(cordicCtrl), 64'h0);
      for (int k = 0; k < SINGLE_WAIT; k++) begin
         tick();
         checkOutput("single_wait_ctrl", 64'(cordicCtrl), 64'h0);
         checkOutput("single_wait_x", 64'(cordicX), 64'h20000000);
      end
      finish_job(0, 0, 1'b0);

      $display("[TB] contention from reset, with backpressure on the first job");
      apply_reset();
      applyStimulus(2'b11, 3, 10);
      applyStimulus(2'b11, 2, 0);
      applyStimulus(2'b11, 4, 1);
      applyStimulus(2'b11, 1, 2);

      $display("[TB] lone requester served back-to-back");
      applyStimulus(2'b10, 2, 0);
      applyStimulus(2'b10, 3, 0);

      $display("[TB] randomized jobs");
      for (int j = 0; j < 8; j++) begin
         mask = 2'($urandom_range(1, 3));
         applyStimulus(mask, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
      end

      $display("[TB] reset in the middle of a wait");
      start_job(2'b01, g);
      tick();
      tick();
      rstN = 1'b0;
      #1;
      check_all_zero("midreset");
      tick();
      tick();
      rstN       = 1'b1;
      last_model = 1;
      cordicXRes = $urandom;
      cordicStatus = $urandom;
      cordicDone = 1'b1;
      tick();
      cordicDone = 1'b0;
      check_all_zero("stray_done");
      tick();
      check_all_zero("stray_done_late");
      reqValid = 2'b10;
      #1;
      checkOutput("after_reset_idle", 64'(reqReady), 64'h2);
      reqValid = 2'b00;
      tick();
      checkOutput("after_reset_busy", 64'(busy), 64'h0);

`ifdef CORDIC_ARB_TIMEOUT_EN
      $display("[TB] watchdog");
      begin
         int first_stop;
         int stop_cycles;
         first_stop  = -1;
         stop_cycles = 0;
         start_job(2'b01, g);
         for (int k = 0; k < 3 * TB_TIMEOUT; k++) begin
            tick();
            if (cordicCtrl[1]) begin
               stop_cycles++;
               if (first_stop < 0) first_stop = k;
            end
            checkOutput("wd_no_start", 64'(cordicCtrl[0]), 64'h0);
         end
         checkOutput("wd_stop_cycle", 64'(first_stop), 64'(TB_TIMEOUT));
         checkOutput("wd_stop_width", 64'(stop_cycles), 64'h1);
         checkOutput("wd_busy", 64'(busy), 64'h1);
         finish_job(g, 1, 1'b1);
         applyStimulus(2'b01, 2, 0);
      end
`else
      $display("[TB] long wait without the watchdog");
      start_job(2'b01, g);
      ok = 1'b1;
      for (int k = 0; k < 1000; k++) begin
         tick();
         if ((cordicCtrl != 32'h0) || (busy !== 1'b1) || (rspValid != 2'b00)) ok = 1'b0;
      end
      checkOutput("long_wait", 64'(ok), 64'h1);
      finish_job(g, 0, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 SHALL have parameter p_WIDTH, default 32: operand/result width.
REQ-002 SHALL have parameter p_TIMEOUT, default 64: watchdog limit in cycles, used only with CORDIC_ARB_TIMEOUT_EN.
REQ-003 SHALL have port clk, in, 1: rising-edge clock.
REQ-004 SHALL have port rstN, in, 1: asynchronous, active-low reset.
REQ-005 SHALL have port reqValid, in, 2: job request; bit i belongs to requester i.
REQ-006 SHALL have port reqReady, out, 2: job accepted on the cycle where reqValid[i] and reqReady[i] are both high.
REQ-007 SHALL have ports reqX, reqY, reqZ, in, 2*p_WIDTH: packed operands; requester i occupies [i*p_WIDTH +: p_WIDTH].
REQ-008 SHALL have port reqCtrl, in, 32: packed 16-bit control halfword per requester; bits 12:2 use the control-register layout, bits 1:0 are ignored.
REQ-009 SHALL have port rspValid, out, 2: result valid for requester i.
REQ-010 SHALL have port rspReady, in, 2: result accepted by requester i.
REQ-011 SHALL have ports rspX, rspY, rspZ, out, p_WIDTH: shared result bus.
REQ-012 SHALL have port rspFlags, out, 16: engine status bits 31:16 (flag half).
REQ-013 SHALL have port rspTimeout, out, 1: watchdog fired for this job.
REQ-014 SHALL have port cordicCtrl, out, 32: engine control-register input.
REQ-015 SHALL have ports cordicX, cordicY, cordicZ, out, p_WIDTH: engine operand inputs.
REQ-016 SHALL have port cordicDone, in, 1: one-cycle pulse marking the engine's post-processing control-register write.
REQ-017 SHALL have ports cordicStatus, in, 32, and cordicXRes, cordicYRes, cordicZRes, in, p_WIDTH: engine results.
REQ-018 SHALL have port busy, out, 1: high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESPOND.
REQ-020 IDLE, one reqValid bit high: grant that requester.
REQ-021 IDLE, both reqValid bits high: grant the requester that is not lastGrant.
REQ-022 IDLE: reqReady[g] SHALL be combinationally high for the granted requester only.
REQ-023 IDLE: on handshake, latch operands, control halfword and grant id g; next state ISSUE.
REQ-024 reqReady SHALL be 0 in all states except IDLE, with at most one bit high.
REQ-025 ISSUE (exactly 1 cycle): cordicCtrl = {16'b0, latched ctrl[15:2], 1'b0, 1'b1}; next state WAIT.
REQ-026 cordicX, cordicY and cordicZ SHALL hold the latched operands from ISSUE through WAIT.
REQ-027 WAIT: cordicCtrl[0] = 0.
REQ-028 WAIT: on cordicDone, capture cordicXRes, cordicYRes, cordicZRes and cordicStatus[31:16]; next state RESPOND.
REQ-029 cordicDone SHALL be ignored in IDLE, ISSUE and RESPOND.
REQ-030 RESPOND: rspValid[g] = 1 with rsp* stable until rspReady[g]; on handshake, lastGrant <= g and next state IDLE.
REQ-031 A response handshake and a new acceptance SHALL never occur in the same cycle; there is at least one IDLE cycle between jobs.
REQ-032 rspValid SHALL be asserted the cycle after cordicDone, with at most one bit high.
REQ-033 A lone requester SHALL be granted back-to-back; round-robin applies only on contention.

Reset
REQ-034 On rstN low: state IDLE; every output, including cordicCtrl and all result registers, 0; lastGrant = 1, so requester 0 wins the first tie.
REQ-035 Reset asserted mid-job SHALL abandon the job with no response; the engine is reset separately.

Configuration
REQ-036 With macro CORDIC_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle, saturating at p_TIMEOUT.
REQ-037 With the macro defined, when the count reaches p_TIMEOUT without cordicDone: cordicCtrl[1] (stop) = 1 for one cycle, stay in WAIT until cordicDone, then respond with rspTimeout = 1.
REQ-038 With the macro undefined: no counter, cordicCtrl[1] always 0, rspTimeout tied 0, p_TIMEOUT unused.

Verification
REQ-039 Single job: req0, X=0x20000000, Y=0, Z=0x10000000, ctrl=0x1F2C; cordicDone 20 cycles later -> cordicCtrl=0x00001F2D for exactly 1 cycle; rspValid=2'b01 the cycle after cordicDone; rspX/Y/Z and rspFlags match the engine values.
REQ-040 Contention: both valid from reset -> order 0,1,0,1 over 4 jobs; reqReady never 2'b11.
REQ-041 Backpressure: rspReady0 held low 10 cycles -> rspValid and data stable; req1 held off; no second cordicCtrl[0] pulse.
REQ-042 Reset mid-WAIT: rstN low 2 cycles, then a stray cordicDone -> no rspValid; all outputs 0; state IDLE.
REQ-043 Macro on, p_TIMEOUT=8, no cordicDone -> cordicCtrl[1]=1 for one cycle 8 cycles into WAIT; later cordicDone -> rspTimeout=1.
REQ-044 Macro off, no cordicDone for 1000 cycles -> busy remains 1; cordicCtrl = 0.
